// File: rtl/ysyx_22041412_idu_pipe.sv
// Instruction-decode stage between IFU and EXU: splits fields, builds the
// extended immediate and format code, and raises class flags.
module ysyx_22041412_idu_pipe #(
  parameter int XLEN = 64,
  parameter bit PIPE = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      opcode,
  output logic [2:0]      func3,
  output logic [6:0]      func7,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            is_load,
  output logic            is_store,
  output logic            is_branch,
  output logic            is_jump,
  output logic            is_word,
  output logic            is_ebreak,
  output logic            illegal
);
  localparam bit RV64 = (XLEN == 64);

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  localparam logic [2:0] FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2, FMT_B = 3'd3,
                         FMT_U = 3'd4, FMT_J = 3'd5, FMT_SYS = 3'd6, FMT_ILL = 3'd7;

  // Raw instruction is kept in the bundle; field outputs are slices of it.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            ld, st, br, jp, wd, eb, il;
  } dec_t;

  dec_t d, b;
  logic bad;
  logic [6:0] op;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sys;

  assign op      = in_instr[6:0];
  assign imm_i   = XLEN'($signed(in_instr[31:20]));
  assign imm_s   = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
  assign imm_b   = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
  assign imm_u   = XLEN'($signed({in_instr[31:12], 12'b0}));
  assign imm_j   = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));
  assign imm_sys = XLEN'(in_instr[19:15]);

  always_comb begin
    d       = '0;
    bad     = 1'b0;
    d.pc    = in_pc;
    d.instr = in_instr;
    case (op)
      OPC_OP:      d.fmt = FMT_R;
      OPC_OP32:    begin d.fmt = FMT_R; d.wd = 1'b1; end
      OPC_OPIMM:   begin d.fmt = FMT_I; d.imm = imm_i; end
      OPC_OPIMM32: begin d.fmt = FMT_I; d.imm = imm_i; d.wd = 1'b1; end
      OPC_LOAD:    begin d.fmt = FMT_I; d.imm = imm_i; d.ld = 1'b1; end
      OPC_JALR:    begin d.fmt = FMT_I; d.imm = imm_i; d.jp = 1'b1; end
      OPC_STORE:   begin d.fmt = FMT_S; d.imm = imm_s; d.st = 1'b1; end
      OPC_BRANCH:  begin d.fmt = FMT_B; d.imm = imm_b; d.br = 1'b1; end
      OPC_LUI,
      OPC_AUIPC:   begin d.fmt = FMT_U; d.imm = imm_u; end
      OPC_JAL:     begin d.fmt = FMT_J; d.imm = imm_j; d.jp = 1'b1; end
      OPC_SYSTEM:  begin d.fmt = FMT_SYS; d.imm = imm_sys; end
      default:     bad = 1'b1;
    endcase
    // Word ops only exist on RV64.
    if (!RV64 && (op == OPC_OP32 || op == OPC_OPIMM32)) bad = 1'b1;
    if (in_instr[1:0] != 2'b11) bad = 1'b1;
    d.eb = (in_instr == 32'h0010_0073);
    if (bad) begin
      d.fmt = FMT_ILL;
      d.imm = '0;
      d.ld  = 1'b0; d.st = 1'b0; d.br = 1'b0; d.jp = 1'b0;
      d.wd  = 1'b0; d.eb = 1'b0;
      d.il  = 1'b1;
    end
  end

  generate
    if (PIPE) begin : g_reg
      dec_t q;
      logic v;
      // Flush beats accept; a stalled bundle is held because in_ready is low.
      always_ff @(posedge clk) begin
        if (rst) begin
          v <= 1'b0;
          q <= '0;
        end else if (flush) begin
          v <= 1'b0;
        end else if (in_valid && in_ready) begin
          v <= 1'b1;
          q <= d;
        end else if (out_ready) begin
          v <= 1'b0;
        end
      end
      assign b         = q;
      assign out_valid = v;
      assign in_ready  = !v || out_ready;
    end else begin : g_comb
      assign b         = d;
      assign out_valid = in_valid && !flush;
      assign in_ready  = out_ready;
    end
  endgenerate

  assign out_pc    = b.pc;
  assign opcode    = b.instr[6:0];
  assign func3     = b.instr[14:12];
  assign func7     = b.instr[31:25];
  assign rs1       = b.instr[19:15];
  assign rs2       = b.instr[24:20];
  assign rd        = b.instr[11:7];
  assign imm       = b.imm;
  assign fmt       = b.fmt;
  assign is_load   = b.ld;
  assign is_store  = b.st;
  assign is_branch = b.br;
  assign is_jump   = b.jp;
  assign is_word   = b.wd;
  assign is_ebreak = b.eb;
  assign illegal   = b.il;
endmodule

// File: tb/tb_ysyx_22041412_idu_pipe.sv
// Bench for the decode stage: RV64 registered build plus RV32 pass-through
// build fed from the same stimulus, checked against a reference decoder.
module tb_ysyx_22041412_idu_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;

  logic a_in_ready, a_out_valid;
  logic [63:0] a_pc, a_imm;
  logic [6:0] a_opcode, a_func7;
  logic [2:0] a_func3, a_fmt;
  logic [4:0] a_rs1, a_rs2, a_rd;
  logic a_ld, a_st, a_br, a_jp, a_wd, a_eb, a_il;

  logic b_in_ready, b_out_valid;
  logic [31:0] b_pc, b_imm;
  logic [6:0] b_opcode, b_func7;
  logic [2:0] b_func3, b_fmt;
  logic [4:0] b_rs1, b_rs2, b_rd;
  logic b_ld, b_st, b_br, b_jp, b_wd, b_eb, b_il;

  ysyx_22041412_idu_pipe #(.XLEN(64), .PIPE(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_pc(a_pc), .opcode(a_opcode), .func3(a_func3), .func7(a_func7), .rs1(a_rs1),
    .rs2(a_rs2), .rd(a_rd), .imm(a_imm), .fmt(a_fmt), .is_load(a_ld), .is_store(a_st),
    .is_branch(a_br), .is_jump(a_jp), .is_word(a_wd), .is_ebreak(a_eb), .illegal(a_il));

  ysyx_22041412_idu_pipe #(.XLEN(32), .PIPE(1'b0)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_pc(b_pc), .opcode(b_opcode), .func3(b_func3), .func7(b_func7), .rs1(b_rs1),
    .rs2(b_rs2), .rd(b_rd), .imm(b_imm), .fmt(b_fmt), .is_load(b_ld), .is_store(b_st),
    .is_branch(b_br), .is_jump(b_jp), .is_word(b_wd), .is_ebreak(b_eb), .illegal(b_il));

  // fl = {load, store, branch, jump, word, ebreak, illegal}
  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [4:0]  rs1, rs2, rd;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic [6:0]  fl;
  } obs_t;

  typedef struct {
    logic [31:0] ins;
    logic [2:0]  f64;
    logic [63:0] i64;
    logic [6:0]  fl64;
    logic [2:0]  f32;
    logic [31:0] i32;
    logic [6:0]  fl32;
  } vec_t;

  int n_vec = 0, n_bad = 0;
  obs_t m;

  function automatic obs_t get64();
    obs_t r;
    r = '{a_out_valid, a_pc, a_opcode, a_func3, a_func7, a_rs1, a_rs2, a_rd, a_imm, a_fmt,
          {a_ld, a_st, a_br, a_jp, a_wd, a_eb, a_il}};
    return r;
  endfunction

  function automatic obs_t get32();
    obs_t r;
    r = '{b_out_valid, {32'b0, b_pc}, b_opcode, b_func3, b_func7, b_rs1, b_rs2, b_rd,
          {32'b0, b_imm}, b_fmt, {b_ld, b_st, b_br, b_jp, b_wd, b_eb, b_il}};
    return r;
  endfunction

  // Reference decoder: immediates assembled arithmetically from a sign-extended word.
  function automatic obs_t ref_dec(input logic [31:0] i, input logic [63:0] pc, input bit x64);
    obs_t r;
    longint s;
    bit bad;
    r = '0; bad = 0;
    r.valid = 1'b1;
    r.pc = x64 ? pc : {32'b0, pc[31:0]};
    r.opcode = i[6:0]; r.func3 = i[14:12]; r.func7 = i[31:25];
    r.rs1 = i[19:15]; r.rs2 = i[24:20]; r.rd = i[11:7];
    s = longint'($signed(i));
    case (i[6:0])
      7'h33: r.fmt = 0;
      7'h3B: begin r.fmt = 0; if (x64) r.fl[2] = 1; else bad = 1; end
      7'h13, 7'h03, 7'h67, 7'h1B: begin
        r.fmt = 1; r.imm = s >>> 20;
        if (i[6:0] == 7'h03) r.fl[6] = 1;
        if (i[6:0] == 7'h67) r.fl[3] = 1;
        if (i[6:0] == 7'h1B) begin if (x64) r.fl[2] = 1; else bad = 1; end
      end
      7'h23: begin r.fmt = 2; r.fl[5] = 1;
        r.imm = ((s >>> 25) << 5) | longint'(i[11:7]); end
      7'h63: begin r.fmt = 3; r.fl[4] = 1;
        r.imm = ((s >>> 31) << 12) | (longint'(i[7]) << 11) | (longint'(i[30:25]) << 5)
              | (longint'(i[11:8]) << 1); end
      7'h37, 7'h17: begin r.fmt = 4; r.imm = (s >>> 12) << 12; end
      7'h6F: begin r.fmt = 5; r.fl[3] = 1;
        r.imm = ((s >>> 31) << 20) | (longint'(i[19:12]) << 12) | (longint'(i[20]) << 11)
              | (longint'(i[30:21]) << 1); end
      7'h73: begin r.fmt = 6; r.imm = longint'(i[19:15]); end
      default: bad = 1;
    endcase
    if (i[1:0] != 2'b11) bad = 1;
    if (i == 32'h0010_0073) r.fl[1] = 1;
    if (bad) begin r.fmt = 7; r.imm = 0; r.fl = 7'b0000001; end
    if (!x64) r.imm[63:32] = 32'b0;
    return r;
  endfunction

  task automatic cmp(input string nm, input obs_t a, input obs_t e, input bit data);
    n_vec++;
    if (a.valid !== e.valid || (data && a !== e)) begin
      n_bad++;
      $display("FAIL %s: got v=%b pc=%h op=%h f3=%h f7=%h rs1=%0d rs2=%0d rd=%0d imm=%h fmt=%0d fl=%b | want v=%b pc=%h op=%h f3=%h f7=%h rs1=%0d rs2=%0d rd=%0d imm=%h fmt=%0d fl=%b",
        nm, a.valid, a.pc, a.opcode, a.func3, a.func7, a.rs1, a.rs2, a.rd, a.imm, a.fmt, a.fl,
        e.valid, e.pc, e.opcode, e.func3, e.func7, e.rs1, e.rs2, e.rd, e.imm, e.fmt, e.fl);
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  // Drive one cycle from a negedge; check comb paths, then the registered result.
  task automatic cyc(input bit r, input bit fl, input bit v, input logic [31:0] ins,
                     input logic [63:0] pc, input bit ordy);
    obs_t e32;
    bit rdy;
    rst = r; flush = fl; in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy;
    #1;
    e32 = ref_dec(ins, pc, 0);
    e32.valid = v && !fl;
    cmp("comb32", get32(), e32, e32.valid);
    rdy = !m.valid || ordy;
    chk("in_ready64", 64'(a_in_ready), 64'(rdy));
    chk("in_ready32", 64'(b_in_ready), 64'(ordy));
    if (r) m = '0;
    else if (fl) m.valid = 1'b0;
    else if (v && rdy) m = ref_dec(ins, pc, 1);
    else if (ordy) m.valid = 1'b0;
    @(negedge clk);
    cmp("pipe64", get64(), m, m.valid);
  endtask

  localparam logic [31:0] I_ADDI = 32'hFFF0_0093, I_SW = 32'h0020_A423, I_LUI = 32'h8000_00B7;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  vec_t tv[15];
  obs_t held;

  initial begin
    tv[0]  = '{32'hFFF00093, 1, ONES,                  7'b0000000, 1, 32'hFFFFFFFF, 7'b0000000};
    tv[1]  = '{32'h0020A423, 2, 64'd8,                 7'b0100000, 2, 32'd8,        7'b0100000};
    tv[2]  = '{32'hFE20AE23, 2, 64'hFFFFFFFFFFFFFFFC,  7'b0100000, 2, 32'hFFFFFFFC, 7'b0100000};
    tv[3]  = '{32'h800000B7, 4, 64'hFFFFFFFF80000000,  7'b0000000, 4, 32'h80000000, 7'b0000000};
    tv[4]  = '{32'h00100073, 6, 64'd0,                 7'b0000010, 6, 32'd0,        7'b0000010};
    tv[5]  = '{32'h0010009B, 1, 64'd1,                 7'b0000100, 7, 32'd0,        7'b0000001};
    tv[6]  = '{32'h00000001, 7, 64'd0,                 7'b0000001, 7, 32'd0,        7'b0000001};
    tv[7]  = '{32'hFE000EE3, 3, 64'hFFFFFFFFFFFFFFFC,  7'b0010000, 3, 32'hFFFFFFFC, 7'b0010000};
    tv[8]  = '{32'hFFFFF06F, 5, 64'hFFFFFFFFFFFFFFFE,  7'b0001000, 5, 32'hFFFFFFFE, 7'b0001000};
    tv[9]  = '{32'h3002D0F3, 6, 64'd5,                 7'b0000000, 6, 32'd5,        7'b0000000};
    tv[10] = '{32'h01012083, 1, 64'd16,                7'b1000000, 1, 32'd16,       7'b1000000};
    tv[11] = '{32'h00008067, 1, 64'd0,                 7'b0001000, 1, 32'd0,        7'b0001000};
    tv[12] = '{32'h002081B3, 0, 64'd0,                 7'b0000000, 0, 32'd0,        7'b0000000};
    tv[13] = '{32'h12345297, 4, 64'h12345000,          7'b0000000, 4, 32'h12345000, 7'b0000000};
    tv[14] = '{32'h002081BB, 0, 64'd0,                 7'b0000100, 7, 32'd0,        7'b0000001};

    rst = 1; flush = 0; in_valid = 0; out_ready = 0; in_instr = 0; in_pc = 0;
    m = '0;
    @(negedge clk); @(negedge clk);
    cmp("reset", get64(), m, 1);
    chk("reset_in_ready", 64'(a_in_ready), 64'd1);

    for (int k = 0; k < 15; k++) begin
      cyc(0, 0, 1, tv[k].ins, 64'h8000_0000 + 64'(k * 4), 1);
      chk("tab_fmt64", 64'(a_fmt), 64'(tv[k].f64));
      chk("tab_imm64", a_imm, tv[k].i64);
      chk("tab_fl64", 64'({a_ld, a_st, a_br, a_jp, a_wd, a_eb, a_il}), 64'(tv[k].fl64));
      chk("tab_fmt32", 64'(b_fmt), 64'(tv[k].f32));
      chk("tab_imm32", 64'(b_imm), 64'(tv[k].i32));
      chk("tab_fl32", 64'({b_ld, b_st, b_br, b_jp, b_wd, b_eb, b_il}), 64'(tv[k].fl32));
    end

    // Backpressure: lui held for three stalled cycles while addi waits.
    cyc(0, 0, 1, I_LUI, 64'h100, 1);
    held = get64();
    chk("bp_lui_imm", a_imm, 64'hFFFF_FFFF_8000_0000);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 1, I_ADDI, 64'h104, 0);
      chk("bp_in_ready", 64'(a_in_ready), 64'd0);
      cmp("bp_hold", get64(), held, 1);
    end
    cyc(0, 0, 1, I_ADDI, 64'h104, 1);
    cmp("bp_release", get64(), ref_dec(I_ADDI, 64'h104, 1), 1);

    // Flush drops a simultaneous accept, and beats a stalled bundle.
    cyc(0, 1, 1, I_SW, 64'h200, 1);
    chk("flush_accept", 64'(a_out_valid), 64'd0);
    cyc(0, 0, 1, I_LUI, 64'h204, 1);
    cyc(0, 1, 0, I_SW, 64'h208, 0);
    chk("flush_hold", 64'(a_out_valid), 64'd0);

    // Reset while a stalled bundle is presented.
    cyc(0, 0, 1, I_ADDI, 64'h300, 1);
    cyc(1, 0, 1, I_SW, 64'h304, 0);
    chk("rst_valid", 64'(a_out_valid), 64'd0);
    chk("rst_imm", a_imm, 64'd0);
    cmp("rst_bundle", get64(), '0, 1);

    for (int k = 0; k < 600; k++) begin
      logic [31:0] ins;
      logic [6:0] ops [12];
      ops = '{7'h03, 7'h13, 7'h17, 7'h1B, 7'h23, 7'h33, 7'h37, 7'h3B, 7'h63, 7'h67, 7'h6F, 7'h73};
      ins = $urandom;
      if ($urandom_range(3) != 0) ins[6:0] = ops[$urandom_range(11)];
      if ($urandom_range(31) == 0) ins = 32'h0010_0073;
      cyc($urandom_range(63) == 0, $urandom_range(15) == 0, $urandom_range(3) != 0, ins,
          {$urandom, $urandom}, $urandom_range(2) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
